// File: rtl/gp_fetch_unit.sv
// Instruction fetch front-end: drives the program ROM word address,
// tags each returned word with its byte PC and buffers it for decode.
module gp_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [29:0] rom_addr,
   input  logic [31:0] rom_inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [29:0] RESET_WORD = RESET_PC[31:2];

   logic [29:0]   fetch_word;
   logic          inflight;
   logic [29:0]   inflight_word;

   logic [31:0]   buf_inst [DEPTH];
   logic [29:0]   buf_word [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic          pop;
   logic          push;
   logic          issue;
   logic [CW:0]   occ;
   logic          unused_bits;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1))
         return '0;
      else
         return p + PW'(1);
   endfunction

   assign unused_bits = ^redirect_pc[1:0];

   assign rom_addr  = fetch_word;
   assign out_valid = (count != '0);
   assign out_inst  = buf_inst[head];
   assign out_pc    = {buf_word[head], 2'b00};

   assign pop  = out_valid & out_ready;
   assign push = inflight & ~redirect_valid;

   // Occupancy counts the word still in flight so the buffer never overflows.
   always_comb begin
      occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
      issue = ~redirect_valid & (occ < (CW+1)'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_word    <= RESET_WORD;
         inflight      <= 1'b0;
         inflight_word <= '0;
      end else if (redirect_valid) begin
         fetch_word    <= redirect_pc[31:2];
         inflight      <= 1'b0;
      end else if (issue) begin
         fetch_word    <= fetch_word + 30'd1;
         inflight      <= 1'b1;
         inflight_word <= fetch_word;
      end else begin
         inflight      <= 1'b0;
      end
   end

   // A redirect flushes everything, including any head popped this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_inst[i] <= '0;
            buf_word[i] <= '0;
         end
      end else if (redirect_valid) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            buf_inst[tail] <= rom_inst;
            buf_word[tail] <= inflight_word;
            tail           <= ptr_next(tail);
         end
         if (pop)
            head <= ptr_next(head);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_gp_fetch_unit.sv
// Directed bench for gp_fetch_unit: fill, backpressure, redirect,
// redirect with pop, PC wrap and mid-stream reset.
module tb_gp_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [29:0] rom_addr;
   logic [31:0] rom_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;

   int n_cmp = 0;
   int n_err = 0;
   int n8;

   gp_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk(clk),
      .rst(rst),
      .rom_addr(rom_addr),
      .rom_inst(rom_inst),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_inst(out_inst),
      .out_pc(out_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [29:0] a);
      case (a)
         30'd0:   return 32'h3c1d1000;
         30'd1:   return 32'h37bd4000;
         30'd2:   return 32'h3c081900;
         30'd3:   return 32'h3c0901ff;
         default: return 32'hA5000000 ^ {2'b00, a};
      endcase
   endfunction

   always_ff @(posedge clk)
      rom_inst <= rom_word(rom_addr);

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset / fill
      do_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         case (c)
            0: begin
               check("fill_v0", 32'(out_valid), 0);
               check("fill_inst0", out_inst, 0);
               check("fill_pc0", out_pc, 0);
               check("fill_addr0", 32'(rom_addr), 0);
            end
            1: check("fill_v1", 32'(out_valid), 0);
            2: begin
               check("fill_v2", 32'(out_valid), 1);
               check("fill_pc2", out_pc, 32'h0);
               check("fill_i2", out_inst, 32'h3c1d1000);
            end
            3: begin
               check("fill_pc3", out_pc, 32'h4);
               check("fill_i3", out_inst, 32'h37bd4000);
            end
            4: begin
               check("fill_pc4", out_pc, 32'h8);
               check("fill_i4", out_inst, 32'h3c081900);
            end
            5: begin
               check("fill_v5", 32'(out_valid), 1);
               check("fill_pc5", out_pc, 32'hC);
               check("fill_i5", out_inst, 32'h3c0901ff);
            end
            default: ;
         endcase
         next_cyc();
      end

      // Backpressure
      do_reset();
      for (int c = 0; c < 11; c++) begin
         out_ready = !(c >= 2 && c <= 6);
         @(negedge clk);
         if (c >= 2 && c <= 6) begin
            check("bp_v", 32'(out_valid), 1);
            check("bp_pc", out_pc, 32'h0);
            check("bp_i", out_inst, 32'h3c1d1000);
         end
         if (c == 4 || c == 6)
            check("bp_addr", 32'(rom_addr), 2);
         if (c == 8) check("bp_pc8", out_pc, 32'h4);
         if (c == 9) check("bp_pc9", out_pc, 32'h8);
         if (c == 10) begin
            check("bp_pc10", out_pc, 32'hC);
            check("bp_i10", out_inst, 32'h3c0901ff);
            check("bp_v10", 32'(out_valid), 1);
         end
         next_cyc();
      end

      // Redirect while streaming
      do_reset();
      for (int c = 0; c < 11; c++) begin
         redirect_valid = (c == 6);
         redirect_pc    = 32'h000000A3;
         @(negedge clk);
         if (c == 6) check("rd_pc6", out_pc, 32'h10);
         if (c == 6) check("rd_i6", out_inst, 32'hA5000004);
         if (c == 7) check("rd_v7", 32'(out_valid), 0);
         if (c == 8) check("rd_v8", 32'(out_valid), 0);
         if (c == 9) begin
            check("rd_v9", 32'(out_valid), 1);
            check("rd_pc9", out_pc, 32'hA0);
            check("rd_i9", out_inst, 32'hA5000028);
         end
         if (c == 10) check("rd_pc10", out_pc, 32'hA4);
         next_cyc();
      end
      redirect_valid = 1'b0;

      // Redirect with pop in the same cycle
      do_reset();
      n8 = 0;
      for (int c = 0; c < 9; c++) begin
         redirect_valid = (c == 4);
         redirect_pc    = 32'h00000040;
         @(negedge clk);
         if (out_valid && out_ready && out_pc == 32'h8) n8++;
         if (c == 4) check("rp_pc4", out_pc, 32'h8);
         if (c == 5) check("rp_v5", 32'(out_valid), 0);
         if (c == 7) begin
            check("rp_pc7", out_pc, 32'h40);
            check("rp_i7", out_inst, 32'hA5000010);
         end
         next_cyc();
      end
      redirect_valid = 1'b0;
      check("rp_pop8_once", 32'(n8), 1);

      // PC wrap
      do_reset();
      for (int c = 0; c < 6; c++) begin
         redirect_valid = (c == 0);
         redirect_pc    = 32'hFFFFFFF8;
         @(negedge clk);
         if (c == 1) check("wr_addr1", 32'(rom_addr), 32'h3FFFFFFE);
         if (c == 2) check("wr_v2", 32'(out_valid), 0);
         if (c == 3) begin
            check("wr_pc3", out_pc, 32'hFFFFFFF8);
            check("wr_i3", out_inst, 32'h9AFFFFFE);
         end
         if (c == 4) begin
            check("wr_pc4", out_pc, 32'hFFFFFFFC);
            check("wr_i4", out_inst, 32'h9AFFFFFF);
         end
         if (c == 5) begin
            check("wr_pc5", out_pc, 32'h0);
            check("wr_i5", out_inst, 32'h3c1d1000);
         end
         next_cyc();
      end
      redirect_valid = 1'b0;

      // Reset mid-stream with a full buffer
      do_reset();
      for (int c = 0; c < 10; c++) begin
         out_ready = (c < 2) || (c >= 6);
         rst       = (c == 5);
         @(negedge clk);
         if (c == 4) check("mr_v4", 32'(out_valid), 1);
         if (c == 6) begin
            check("mr_v6", 32'(out_valid), 0);
            check("mr_pc6", out_pc, 32'h0);
            check("mr_addr6", 32'(rom_addr), 0);
         end
         if (c == 7) check("mr_v7", 32'(out_valid), 0);
         if (c == 8) begin
            check("mr_v8", 32'(out_valid), 1);
            check("mr_pc8", out_pc, 32'h0);
            check("mr_i8", out_inst, 32'h3c1d1000);
         end
         if (c == 9) check("mr_pc9", out_pc, 32'h4);
         next_cyc();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
